usb_cmd_ctrl: RTL
=================

Name: usb_cmd_ctrl

Overview:
- Command/mode controller directly downstream of the USB FIFO interface (usb_int) on the clkusb domain.
- Owns usb_int's wr_en and start_read inputs:
  - keeps the link streaming ADC data by default;
  - when the host has bytes pending (rxf low), drains the current write, runs one 32-bit read and consumes the returned word.
- Decodes the word into radar configuration registers and sweep enable.

Parameters:
- NREG, 8, number of 12-bit config registers (max 16).
- TIMEOUT, 15, clkusb cycles allowed in WAIT_BUSY and in WAIT_DONE before abort.
- OP_WR, 8'h01, opcode: write register.
- OP_GO, 8'h02, opcode: set sweep enable.
- OP_STOP, 8'h03, opcode: clear sweep enable.
- OP_CLR, 8'h04, opcode: clear all registers and sweep enable.

Ports:
- clkusb  in  1  USB-side clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- i_data_rd  in  32  word assembled by usb_int; valid when i_busy falls after a read.
- i_busy  in  1  usb_int busy (read or write in progress).
- rxf  in  1  FT FIFO RX flag, active-low (low = host data pending); asynchronous to clkusb.
- o_wr_en  out  1  to usb_int wr_en; 1 = streaming writes allowed.
- o_start_read  out  1  to usb_int start_read; single-cycle pulse.
- o_cfg  out  NREG*12  flattened register file; reg k at bits [12k+11:12k].
- o_sweep_en  out  1  chirp sweep enable to the radar timing block.
- o_cmd_stb  out  1  one-cycle pulse per accepted command.
- o_err_cnt  out  8  saturating error count.

Behaviour:
- Reset (async assert, sync release): state STREAM, o_wr_en=0, o_start_read=0, o_cfg=0, o_sweep_en=0, o_cmd_stb=0, o_err_cnt=0, timeout counter 0, rxf synchronizer flops reset to 1.
  - o_wr_en goes 1 on the first edge after release.
- rxf passes through a 2-flop synchronizer; rxf_s is the synchronized value.
- FSM states: STREAM, DRAIN, ARM, WAIT_BUSY, WAIT_DONE, DECODE.
- STREAM:
  - o_wr_en=1.
  - rxf_s==0 -> DRAIN.
- DRAIN:
  - o_wr_en=0.
  - i_busy==0 -> ARM; otherwise hold.
  - No timeout in this state; a usb_int write lasts 2 cycles.
- ARM:
  - o_start_read=1 for exactly this one cycle -> WAIT_BUSY.
  - Counter cleared.
- WAIT_BUSY:
  - i_busy==1 -> WAIT_DONE, counter cleared.
  - Counter reaches TIMEOUT -> err++ and STREAM. This covers rxf deasserted before usb_int sampled the start pulse.
- WAIT_DONE:
  - i_busy==0 -> latch i_data_rd into cmd register -> DECODE.
  - Counter reaches TIMEOUT -> err++ and STREAM.
- DECODE:
  - One cycle -> STREAM.
  - Effects are registered and visible on the edge leaving DECODE, together with o_cmd_stb=1 for one cycle.
- Word format:
  - [31:24] opcode.
  - [23:20] addr.
  - [19:8] value.
  - [7:0] checksum (ignored unless the optional feature is enabled).
- Decode rules:
  - OP_WR: addr<NREG -> reg[addr]=value, accepted; addr>=NREG -> error, no write.
  - OP_GO -> o_sweep_en=1. OP_STOP -> o_sweep_en=0.
  - OP_CLR -> all regs=0 and o_sweep_en=0.
  - Any other opcode -> error, no effect, no strobe.
- o_err_cnt increments by exactly 1 per error event and saturates at 8'hFF.
- o_start_read is never asserted outside ARM; o_wr_en is never 1 outside STREAM.
- Latency: i_busy fall sampled in WAIT_DONE -> o_cfg/o_cmd_stb update 2 edges later.
- rxf still low on return to STREAM -> next read cycle starts immediately. STREAM always holds at least one cycle so ADC writes can interleave.
- rst mid-transaction: immediate return to reset values; the partial word is discarded.

Optional Feature:
- Macro USB_CMD_CHECKSUM_EN.
- Defined: DECODE requires cmd[7:0] == cmd[31:24]^cmd[23:16]^cmd[15:8]. On mismatch: error counted, no register/sweep change, no o_cmd_stb.
- Undefined: cmd[7:0] ignored; no checksum logic is synthesized.

Test Plan:
- Reset, rxf=1, i_busy=0 -> o_wr_en=1 from the 1st edge after release and stays 1; o_start_read never pulses; o_cfg=0.
- rxf=0, usb_int model busy 5 cycles, returns 32'h01_3_ABC_xx (checksum 8'h01^8'h3A^8'hBC=8'h87) -> o_wr_en drops, one o_start_read pulse, reg3=12'hABC, one o_cmd_stb, o_err_cnt=0.
- rxf=0 while i_busy=1 from a write -> FSM holds in DRAIN with o_wr_en=0 until i_busy=0, then the start pulse follows exactly 1 cycle later.
- Start pulse never answered (i_busy stays 0) -> after 15 cycles o_err_cnt=1 and o_wr_en=1.
- Words 0x02000002, then 0xFF0000FF, then 0x01A12332 (addr 10 >= 8) -> o_sweep_en=1; o_err_cnt=2; no register changed.
- With USB_CMD_CHECKSUM_EN, word 0x01_2_555_00 (bad checksum) -> reg2 unchanged, o_err_cnt +1.
- Without USB_CMD_CHECKSUM_EN, the same word -> reg2=12'h555.

Source files
------------

// File: rtl/usb_cmd_ctrl_if.sv
// usb_int link bundle: streaming/read control out, busy and read word back.
// master = usb_cmd_ctrl side, slave = usb_int side.
interface usb_cmd_ctrl_if;
  logic [31:0] i_data_rd;
  logic        i_busy;
  logic        o_wr_en;
  logic        o_start_read;

  modport master (
    input  i_data_rd,
    input  i_busy,
    output o_wr_en,
    output o_start_read
  );

  modport slave (
    output i_data_rd,
    output i_busy,
    input  o_wr_en,
    input  o_start_read
  );
endinterface

// File: rtl/usb_cmd_ctrl.sv
// USB command controller: streams by default, reads one host word when rxf
// is low and decodes it into NREG 12-bit config registers plus sweep enable.
// Ports: clkusb, rst (async high), rxf (async, active-low), usb (link
// bundle: i_data_rd, i_busy in; o_wr_en, o_start_read out), o_cfg,
// o_sweep_en, o_cmd_stb, o_err_cnt.
// Optional: define USB_CMD_CHECKSUM_EN to require cmd[7:0] to be the XOR
// of the three upper bytes before a command is accepted.
module usb_cmd_ctrl #(
  parameter int         NREG    = 8,
  parameter int         TIMEOUT = 15,
  parameter logic [7:0] OP_WR   = 8'h01,
  parameter logic [7:0] OP_GO   = 8'h02,
  parameter logic [7:0] OP_STOP = 8'h03,
  parameter logic [7:0] OP_CLR  = 8'h04
) (
  input  logic                 clkusb,
  input  logic                 rst,
  input  logic                 rxf,
  usb_cmd_ctrl_if.master       usb,
  output logic [NREG*12-1:0]   o_cfg,
  output logic                 o_sweep_en,
  output logic                 o_cmd_stb,
  output logic [7:0]           o_err_cnt
);

  localparam logic [2:0] STREAM    = 3'd0;
  localparam logic [2:0] DRAIN     = 3'd1;
  localparam logic [2:0] ARM       = 3'd2;
  localparam logic [2:0] WAIT_BUSY = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] DECODE    = 3'd5;

  localparam int         TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [4:0] NREG5 = 5'(NREG);

`ifdef USB_CMD_CHECKSUM_EN
  localparam int CLO = 0;
`else
  localparam int CLO = 8;
`endif

  logic [2:0]    state, nstate;
  logic [TW-1:0] cnt;
  logic          cnt_clr, cnt_inc;
  logic          tmo_err, latch;
  logic          rxf_m, rxf_s;
  logic [31:CLO] cmd;
  logic [11:0]   regs [NREG];

  logic [7:0]    opc;
  logic [3:0]    addr;
  logic [11:0]   val;
  logic          csum_ok;
  logic          is_wr, is_go, is_stop, is_clr;
  logic          accept;
  logic          dec_err;
  logic          err_evt;

  always_ff @(posedge clkusb or posedge rst) begin
    if (rst) begin
      rxf_m <= 1'b1;
      rxf_s <= 1'b1;
    end else begin
      rxf_m <= rxf;
      rxf_s <= rxf_m;
    end
  end

  always_comb begin
    nstate  = state;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    tmo_err = 1'b0;
    latch   = 1'b0;
    case (state)
      STREAM: begin
        if (!rxf_s) nstate = DRAIN;
      end
      DRAIN: begin
        if (!usb.i_busy) nstate = ARM;
      end
      ARM: begin
        cnt_clr = 1'b1;
        nstate  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (usb.i_busy) begin
          cnt_clr = 1'b1;
          nstate  = WAIT_DONE;
        end else if (cnt == TLAST) begin
          tmo_err = 1'b1;
          nstate  = STREAM;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!usb.i_busy) begin
          latch  = 1'b1;
          nstate = DECODE;
        end else if (cnt == TLAST) begin
          tmo_err = 1'b1;
          nstate  = STREAM;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DECODE: begin
        nstate = STREAM;
      end
      default: begin
        nstate = STREAM;
      end
    endcase
  end

  always_comb begin
    opc  = cmd[31:24];
    addr = cmd[23:20];
    val  = cmd[19:8];
`ifdef USB_CMD_CHECKSUM_EN
    csum_ok = (cmd[7:0] == (cmd[31:24] ^ cmd[23:16] ^ cmd[15:8]));
`else
    csum_ok = 1'b1;
`endif
    is_wr   = (opc == OP_WR) && ({1'b0, addr} < NREG5);
    is_go   = (opc == OP_GO);
    is_stop = (opc == OP_STOP);
    is_clr  = (opc == OP_CLR);
    accept  = csum_ok && (is_wr || is_go || is_stop || is_clr);
    dec_err = (state == DECODE) && !accept;
    err_evt = tmo_err || dec_err;
  end

  always_ff @(posedge clkusb or posedge rst) begin
    if (rst) begin
      state            <= STREAM;
      cnt              <= '0;
      cmd              <= '0;
      usb.o_wr_en      <= 1'b0;
      usb.o_start_read <= 1'b0;
      o_sweep_en       <= 1'b0;
      o_cmd_stb        <= 1'b0;
      o_err_cnt        <= 8'h00;
      for (int k = 0; k < NREG; k++) regs[k] <= 12'h000;
    end else begin
      state            <= nstate;
      usb.o_wr_en      <= (nstate == STREAM);
      usb.o_start_read <= (nstate == ARM);
      o_cmd_stb        <= (state == DECODE) && accept;

      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;

      if (latch) cmd <= usb.i_data_rd[31:CLO];

      if (err_evt && (o_err_cnt != 8'hFF))
        o_err_cnt <= o_err_cnt + 8'h01;

      if ((state == DECODE) && accept) begin
        if (is_go)   o_sweep_en <= 1'b1;
        if (is_stop) o_sweep_en <= 1'b0;
        if (is_clr) begin
          o_sweep_en <= 1'b0;
          for (int k = 0; k < NREG; k++) regs[k] <= 12'h000;
        end
        if (is_wr) begin
          for (int k = 0; k < NREG; k++)
            if (addr == 4'(k)) regs[k] <= val;
        end
      end
    end
  end

  always_comb begin
    o_cfg = '0;
    for (int k = 0; k < NREG; k++) o_cfg[12*k +: 12] = regs[k];
  end

endmodule
